// File: rtl/uart_fifo_bridge_if.sv
// Host-side and uart-side signal bundle for uart_fifo_bridge.
// The bridge takes the slave modport; the host/uart environment takes master.
interface uart_fifo_bridge_if #(
  parameter int unsigned TX_AW = 4,
  parameter int unsigned RX_AW = 4
);
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             tx_full;
  logic [TX_AW:0]   tx_count;
  logic             rd_en;
  logic [7:0]       rd_data;
  logic             rx_empty;
  logic [RX_AW:0]   rx_count;
  logic             rx_overflow;
  logic             clr_ovf;
  logic             uart_transmit_n;
  logic [7:0]       uart_tx_byte;
  logic             uart_is_transmitting;
  logic             uart_received;
  logic [7:0]       uart_rx_byte;
  logic             uart_recv_error;
  logic [7:0]       err_count;

  modport slave (
    input  wr_en, wr_data, rd_en, clr_ovf,
    input  uart_is_transmitting, uart_received, uart_rx_byte, uart_recv_error,
    output tx_full, tx_count, rd_data, rx_empty, rx_count, rx_overflow,
    output uart_transmit_n, uart_tx_byte, err_count
  );

  modport master (
    output wr_en, wr_data, rd_en, clr_ovf,
    output uart_is_transmitting, uart_received, uart_rx_byte, uart_recv_error,
    input  tx_full, tx_count, rd_data, rx_empty, rx_count, rx_overflow,
    input  uart_transmit_n, uart_tx_byte, err_count
  );
endinterface

// File: rtl/uart_fifo_bridge.sv
// Byte-buffered TX/RX FIFO front end for the uart core with a registered launch FSM.
// Optional frame-error counter enabled by defining UART_BRIDGE_ERRCNT_EN.
module uart_fifo_bridge #(
  parameter int unsigned TX_AW = 4,
  parameter int unsigned RX_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  uart_fifo_bridge_if.slave  bus
);
  localparam int unsigned    TX_DEPTH    = 1 << TX_AW;
  localparam int unsigned    RX_DEPTH    = 1 << RX_AW;
  localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);

  typedef enum logic [1:0] {T_IDLE, T_LAUNCH, T_WAIT_BUSY, T_WAIT_DONE} tx_state_e;

  tx_state_e          state_q, state_d;
  logic [1:0]         tmo_q, tmo_d;
  logic               tx_n_q, tx_n_d;
  logic [7:0]         tx_byte_q, tx_byte_d;

  logic [7:0]         tx_mem_q [TX_DEPTH];
  logic [7:0]         tx_mem_d [TX_DEPTH];
  logic [TX_AW-1:0]   tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TX_AW:0]     tx_count_q, tx_count_d;

  logic [7:0]         rx_mem_q [RX_DEPTH];
  logic [7:0]         rx_mem_d [RX_DEPTH];
  logic [RX_AW-1:0]   rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RX_AW:0]     rx_count_q, rx_count_d;
  logic               rx_ovf_q, rx_ovf_d;

  logic tx_full, tx_push, tx_pop;
  logic rx_full, rx_empty, rx_push, rx_pop;

  always_comb begin
    tx_full   = (tx_count_q == TX_FULL_CNT);
    tx_push   = bus.wr_en && !tx_full;
    tx_pop    = 1'b0;
    state_d   = state_q;
    tmo_d     = tmo_q;
    tx_n_d    = 1'b1;
    tx_byte_d = tx_byte_q;

    case (state_q)
      T_IDLE: begin
        if (tx_count_q != '0 && !bus.uart_is_transmitting) begin
          tx_byte_d = tx_mem_q[tx_rd_ptr_q];
          tx_n_d    = 1'b0;
          tx_pop    = 1'b1;
          state_d   = T_LAUNCH;
        end
      end
      T_LAUNCH: begin
        tmo_d   = '0;
        state_d = T_WAIT_BUSY;
      end
      T_WAIT_BUSY: begin
        // Four cycles here without busy means the uart missed the strobe.
        if (bus.uart_is_transmitting) begin
          state_d = T_WAIT_DONE;
        end else if (tmo_q == 2'd3) begin
          state_d = T_IDLE;
        end else begin
          tmo_d = tmo_q + 2'd1;
        end
      end
      T_WAIT_DONE: begin
        if (!bus.uart_is_transmitting) state_d = T_IDLE;
      end
      default: state_d = T_IDLE;
    endcase

    tx_mem_d    = tx_mem_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    if (tx_push) begin
      tx_mem_d[tx_wr_ptr_q] = bus.wr_data;
      tx_wr_ptr_d           = tx_wr_ptr_q + 1'b1;
    end
    if (tx_pop) tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + 1'b1;
      2'b01:   tx_count_d = tx_count_q - 1'b1;
      default: tx_count_d = tx_count_q;
    endcase
  end

  always_comb begin
    rx_full  = (rx_count_q == RX_FULL_CNT);
    rx_empty = (rx_count_q == '0);
    rx_pop   = bus.rd_en && !rx_empty;
    // A full FIFO still accepts a byte when a read frees the head slot.
    rx_push  = bus.uart_received && (!rx_full || rx_pop);

    rx_mem_d    = rx_mem_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    if (rx_push) begin
      rx_mem_d[rx_wr_ptr_q] = bus.uart_rx_byte;
      rx_wr_ptr_d           = rx_wr_ptr_q + 1'b1;
    end
    if (rx_pop) rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + 1'b1;
      2'b01:   rx_count_d = rx_count_q - 1'b1;
      default: rx_count_d = rx_count_q;
    endcase

    if (bus.uart_received && rx_full && !rx_pop) begin
      rx_ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      rx_ovf_d = 1'b0;
    end else begin
      rx_ovf_d = rx_ovf_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= T_IDLE;
      tmo_q       <= '0;
      tx_n_q      <= 1'b1;
      tx_byte_q   <= '0;
      tx_mem_q    <= '{default: '0};
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_mem_q    <= '{default: '0};
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      rx_ovf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      tx_n_q      <= tx_n_d;
      tx_byte_q   <= tx_byte_d;
      tx_mem_q    <= tx_mem_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_mem_q    <= rx_mem_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
      rx_ovf_q    <= rx_ovf_d;
    end
  end

  assign bus.tx_full         = tx_full;
  assign bus.tx_count        = tx_count_q;
  assign bus.rx_empty        = rx_empty;
  assign bus.rx_count        = rx_count_q;
  assign bus.rd_data         = rx_empty ? '0 : rx_mem_q[rx_rd_ptr_q];
  assign bus.rx_overflow     = rx_ovf_q;
  assign bus.uart_transmit_n = tx_n_q;
  assign bus.uart_tx_byte    = tx_byte_q;

`ifdef UART_BRIDGE_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.uart_recv_error) begin
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end else if (bus.clr_ovf) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign bus.err_count = err_cnt_q;
`else
  logic unused_recv_error;
  assign unused_recv_error = bus.uart_recv_error;
  assign bus.err_count     = '0;
`endif
endmodule
